// File: rtl/nec_ir_rx_param.sv
// NEC IR frame decoder with derived timing windows, gated repeat and coded errors.
// Define NEC_IR_EXT_ADDR_EN to accept extended NEC (16 independent address bits).
module nec_ir_rx_param #(
  parameter int unsigned CLK_FREQ_HZ       = 50_000_000,
  parameter int unsigned TOL_PCT           = 20,
  parameter int unsigned REPEAT_TIMEOUT_MS = 120,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        inf_in,
  output logic        frame_valid,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        repeat_en,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic        busy
);

  function automatic longint unsigned nom(input longint unsigned t_us);
    return t_us * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
  endfunction

  function automatic longint unsigned win_lo(input longint unsigned t_us);
    return nom(t_us) * (64'd100 - 64'(TOL_PCT)) / 64'd100;
  endfunction

  function automatic longint unsigned win_hi(input longint unsigned t_us);
    return nom(t_us) * (64'd100 + 64'(TOL_PCT)) / 64'd100;
  endfunction

  localparam int unsigned CW = $clog2(win_hi(64'd9000)) + 1;

  localparam logic [CW-1:0] LEAD_LO = CW'(win_lo(64'd9000));
  localparam logic [CW-1:0] LEAD_HI = CW'(win_hi(64'd9000));
  localparam logic [CW-1:0] HDR_LO  = CW'(win_lo(64'd4500));
  localparam logic [CW-1:0] HDR_HI  = CW'(win_hi(64'd4500));
  localparam logic [CW-1:0] RPT_LO  = CW'(win_lo(64'd2250));
  localparam logic [CW-1:0] RPT_HI  = CW'(win_hi(64'd2250));
  localparam logic [CW-1:0] BIT_LO  = CW'(win_lo(64'd560));
  localparam logic [CW-1:0] BIT_HI  = CW'(win_hi(64'd560));
  localparam logic [CW-1:0] ONE_LO  = CW'(win_lo(64'd1690));
  localparam logic [CW-1:0] ONE_HI  = CW'(win_hi(64'd1690));

  localparam longint unsigned RPT_CYC = 64'(REPEAT_TIMEOUT_MS) * 64'(CLK_FREQ_HZ) / 64'd1000;
  localparam int unsigned     RW      = $clog2(RPT_CYC + 64'd1);
  localparam logic [RW-1:0]   RPT_MAX = RW'(RPT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_L, S_LEAD_H, S_BIT_L, S_BIT_H, S_STOP_L, S_RPT_L
  } state_t;

  function automatic logic in_win(input logic [CW-1:0] v, input logic [CW-1:0] lo,
                                  input logic [CW-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_q;
  logic [CW-1:0]          cnt_q;
  logic [RW-1:0]          rpt_q;
  logic [31:0]            shift_q;
  logic [4:0]             bit_idx_q;
  logic                   fall_c, rise_c, cmd_ok_c, addr_ok_c;
  logic [CW-1:0]          tmo_hi_c;
  logic [2:0]             err_c;

  // Input synchroniser (idles high) plus edge-detect flop
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '1;
      in_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inf_in};
      in_q   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_c = in_q & ~sync_q[SYNC_STAGES-1];
  assign rise_c = ~in_q & sync_q[SYNC_STAGES-1];

  // Saturating width counter, restarted by every edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)             cnt_q <= '0;
    else if (fall_c || rise_c)  cnt_q <= '0;
    else if (cnt_q != '1)       cnt_q <= cnt_q + CW'(1);
  end

  assign cmd_ok_c = (shift_q[31:24] == ~shift_q[23:16]);
`ifdef NEC_IR_EXT_ADDR_EN
  assign addr_ok_c = 1'b1;
`else
  assign addr_ok_c = (shift_q[15:8] == ~shift_q[7:0]);
`endif

  always_comb begin
    tmo_hi_c = '1;
    case (state_q)
      S_LEAD_L:                   tmo_hi_c = LEAD_HI;
      S_LEAD_H:                   tmo_hi_c = HDR_HI;
      S_BIT_L, S_STOP_L, S_RPT_L: tmo_hi_c = BIT_HI;
      S_BIT_H:                    tmo_hi_c = ONE_HI;
      default:                    tmo_hi_c = '1;
    endcase
  end

  // Error decision; a timeout outranks an edge arriving on the same cycle
  always_comb begin
    err_c = 3'd0;
    if (state_q != S_IDLE && cnt_q > tmo_hi_c) begin
      err_c = 3'd5;
    end else begin
      case (state_q)
        S_LEAD_L: if (rise_c && !in_win(cnt_q, LEAD_LO, LEAD_HI)) err_c = 3'd1;
        S_LEAD_H: if (fall_c && !in_win(cnt_q, HDR_LO, HDR_HI) &&
                      !in_win(cnt_q, RPT_LO, RPT_HI)) err_c = 3'd1;
        S_BIT_L:  if (rise_c && !in_win(cnt_q, BIT_LO, BIT_HI)) err_c = 3'd2;
        S_BIT_H:  if (fall_c && !in_win(cnt_q, BIT_LO, BIT_HI) &&
                      !in_win(cnt_q, ONE_LO, ONE_HI)) err_c = 3'd2;
        S_STOP_L: if (rise_c) begin
                    if (!in_win(cnt_q, BIT_LO, BIT_HI)) err_c = 3'd2;
                    else if (!(cmd_ok_c && addr_ok_c)) err_c = 3'd3;
                  end
        S_RPT_L:  if (rise_c) begin
                    if (!in_win(cnt_q, BIT_LO, BIT_HI)) err_c = 3'd1;
                    else if (rpt_q == RPT_MAX)         err_c = 3'd4;
                  end
        default:  err_c = 3'd0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      rpt_q       <= RPT_MAX;
      addr        <= '0;
      cmd         <= '0;
      frame_valid <= 1'b0;
      repeat_en   <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      repeat_en   <= 1'b0;
      frame_err   <= 1'b0;
      if (rpt_q != RPT_MAX) rpt_q <= rpt_q + RW'(1);
      if (err_c != 3'd0) begin
        frame_err <= 1'b1;
        err_code  <= err_c;
        state_q   <= S_IDLE;
        busy      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (fall_c) begin
            state_q <= S_LEAD_L;
            busy    <= 1'b1;
          end
          S_LEAD_L: if (rise_c) state_q <= S_LEAD_H;
          S_LEAD_H: if (fall_c) begin
            if (in_win(cnt_q, HDR_LO, HDR_HI)) begin
              state_q   <= S_BIT_L;
              bit_idx_q <= '0;
            end else begin
              state_q <= S_RPT_L;
            end
          end
          S_BIT_L: if (rise_c) state_q <= S_BIT_H;
          S_BIT_H: if (fall_c) begin
            shift_q   <= {in_win(cnt_q, ONE_LO, ONE_HI), shift_q[31:1]};
            bit_idx_q <= bit_idx_q + 5'd1;
            state_q   <= (bit_idx_q == 5'd31) ? S_STOP_L : S_BIT_L;
          end
          S_STOP_L: if (rise_c) begin
            addr        <= shift_q[15:0];
            cmd         <= shift_q[23:16];
            frame_valid <= 1'b1;
            rpt_q       <= '0;
            state_q     <= S_IDLE;
            busy        <= 1'b0;
          end
          S_RPT_L: if (rise_c) begin
            repeat_en <= 1'b1;
            rpt_q     <= '0;
            state_q   <= S_IDLE;
            busy      <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_rx_param.sv
// Directed scoreboard bench for nec_ir_rx_param; clock scaled to 50 kHz (20 us/cycle)
// so whole frames and repeat gaps fit a short run. Honours NEC_IR_EXT_ADDR_EN.
`timescale 1ns/1ps
module tb_nec_ir_rx_param;
  localparam int unsigned CLK_HZ     = 50_000;
  localparam int          US_PER_CLK = 1_000_000 / CLK_HZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inf = 1'b1;
  logic        frame_valid, repeat_en, frame_err, busy;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic [2:0]  err_code;

  nec_ir_rx_param #(
    .CLK_FREQ_HZ(CLK_HZ), .TOL_PCT(20), .REPEAT_TIMEOUT_MS(120), .SYNC_STAGES(2)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .inf_in(inf),
    .frame_valid(frame_valid), .addr(addr), .cmd(cmd), .repeat_en(repeat_en),
    .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #10000 clk = ~clk;

  typedef struct {
    logic [2:0]  ev;    // {frame_err, repeat_en, frame_valid}
    logic [2:0]  code;
    logic [15:0] addr;
    logic [7:0]  cmd;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_addr = '0;
  logic [7:0]  exp_cmd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pops one expectation per output pulse and compares the whole result
  always @(negedge clk) begin
    if (rst_n && (frame_valid || repeat_en || frame_err)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 32'({frame_err, repeat_en, frame_valid}), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_event"}, 32'({frame_err, repeat_en, frame_valid}), 32'(e.ev));
        if (e.ev[2]) chk({e.tag, "_err_code"}, 32'(err_code), 32'(e.code));
        chk({e.tag, "_addr"}, 32'(addr), 32'(e.addr));
        chk({e.tag, "_cmd"}, 32'(cmd), 32'(e.cmd));
      end
    end
  end

  task automatic push(input string tag, input logic [2:0] ev, input logic [2:0] code);
    exp_t x;
    x.tag = tag; x.ev = ev; x.code = code; x.addr = exp_addr; x.cmd = exp_cmd;
    sbq.push_back(x);
  endtask

  task automatic push_valid(input string tag, input logic [15:0] a, input logic [7:0] c);
    exp_addr = a;
    exp_cmd  = c;
    push(tag, 3'b001, 3'd0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL %s_timeout observed_pending=%0d expected_pending=0", tag, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic level(input logic v, input int us);
    inf = v;
    repeat (us / US_PER_CLK) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] d, input int nbits);
    level(1'b0, 9000);
    level(1'b1, 4500);
    for (int i = 0; i < nbits; i++) begin
      level(1'b0, 560);
      level(1'b1, d[i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(input logic [31:0] d);
    send_bits(d, 32);
    level(1'b0, 560);
    level(1'b1, 2000);
  endtask

  task automatic send_repeat();
    level(1'b0, 9000);
    level(1'b1, 2250);
    level(1'b0, 560);
    level(1'b1, 2000);
  endtask

  function automatic logic [31:0] mk(input logic [7:0] lo, input logic [7:0] hi,
                                     input logic [7:0] c, input logic [7:0] ci);
    return {ci, c, hi, lo};
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_repeat_en"}, 32'(repeat_en), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("reset_released");

    // Repeat before any good frame: timer starts expired
    push("rpt_cold", 3'b100, 3'd4);
    send_repeat();
    wait_drain("rpt_cold");

    push_valid("frame_ff00_45", 16'hFF00, 8'h45);
    send_frame(mk(8'h00, 8'hFF, 8'h45, 8'hBA));
    wait_drain("frame_ff00_45");

    level(1'b1, 98000);
    push("rpt_100ms", 3'b010, 3'd0);
    send_repeat();
    wait_drain("rpt_100ms");

    level(1'b1, 128000);
    push("rpt_130ms", 3'b100, 3'd4);
    send_repeat();
    wait_drain("rpt_130ms");
    chk("rpt_130ms_busy", 32'(busy), 32'd0);

    push("short_leader", 3'b100, 3'd1);
    level(1'b0, 6000);
    level(1'b1, 200);
    wait_drain("short_leader");
    @(negedge clk);
    chk("short_leader_busy", 32'(busy), 32'd0);

    push("bad_cmd_inv", 3'b100, 3'd3);
    send_frame(mk(8'h00, 8'hFF, 8'h45, 8'h45));
    wait_drain("bad_cmd_inv");

`ifdef NEC_IR_EXT_ADDR_EN
    push_valid("ext_addr", 16'h3412, 8'h10);
`else
    push("ext_addr", 3'b100, 3'd3);
`endif
    send_frame(mk(8'h12, 8'h34, 8'h10, 8'hEF));
    wait_drain("ext_addr");

    // Stuck low after 10 data bits: BIT_L timeout
    push("stuck_low", 3'b100, 3'd5);
    send_bits(mk(8'h01, 8'hFE, 8'h22, 8'hDD), 10);
    level(1'b0, 2000);
    wait_drain("stuck_low");
    chk("stuck_low_busy", 32'(busy), 32'd0);
    level(1'b1, 2000);

    // Reset mid-frame, then a full frame must decode cleanly
    send_bits(mk(8'h55, 8'hAA, 8'h0F, 8'hF0), 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("midframe_reset");
    exp_addr = '0;
    exp_cmd  = '0;
    rst_n = 1'b1;
    level(1'b1, 1000);
    push_valid("post_reset_frame", 16'hFE01, 8'h22);
    send_frame(mk(8'h01, 8'hFE, 8'h22, 8'hDD));
    wait_drain("post_reset_frame");
    chk("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
